serial_pad_reader: RTL and testbench

- Generalised successor to the single-NES-pad byte peripheral.
- Drives a shared latch/clock pair to NUM_PADS daisy-free serial gamepads and shifts in NUM_BITS per pad in parallel: NES is 8 bits, SNES is 16.
- Supports a manual trigger and auto-polling.
- Presents debounced-by-scan, active-high button vectors to the TinyQV peripheral register layer.

---
 rtl/serial_pad_pkg.sv | 16 +
 rtl/serial_pad_phase_timer.sv | 28 ++
 rtl/serial_pad_reader.sv | 162 ++++++++++++++++
 tb/tb_serial_pad_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pad_pkg.sv
// Shared types and constants for the serial gamepad reader.
package serial_pad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int unsigned NES_BITS  = 8;
    localparam int unsigned SNES_BITS = 16;
    localparam int unsigned POLL_W    = 16;

endpackage

// File: rtl/serial_pad_phase_timer.sv
// Phase timer: counts cycles inside a timed state and flags its last cycle.
// The count returns to zero on the last cycle, so every state change restarts it.
module serial_pad_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CNT_W-1:0] limit,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt;

    assign last_c = run && (cnt == limit);

    // Free-running phase count, cleared outside timed states and at terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || last_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_pad_reader.sv
// Serial gamepad reader: shared latch/clock, one data line per pad,
// NUM_BITS shifted per pad per scan, manual start or auto-polling.
// Optional macro SERIAL_PAD_EDGE_EN adds the pressed_edge output.
module serial_pad_reader
    import serial_pad_pkg::*;
#(
    parameter int unsigned        NUM_PADS    = 2,
    parameter int unsigned        NUM_BITS    = NES_BITS,
    parameter int unsigned        HALF_CYCLES = 6,
    parameter logic [POLL_W-1:0]  POLL_CYCLES = 16'd50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         auto_en,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic                         busy
`ifdef SERIAL_PAD_EDGE_EN
    ,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed_edge
`endif
);

    localparam int unsigned PH_W = $clog2(2 * HALF_CYCLES);
    localparam int unsigned BI_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int unsigned BW   = NUM_PADS * NUM_BITS;

    state_t            state;
    logic [BI_W-1:0]   bit_idx;
    logic [POLL_W-1:0] poll_cnt;
    logic              sync_q1 [NUM_PADS];
    logic              sync_q2 [NUM_PADS];
    logic [NUM_BITS-1:0] shift_q [NUM_PADS];
    logic [BW-1:0]     shift_flat;

    logic              run_c;
    logic              tick_c;
    logic [PH_W-1:0]   limit_c;
    logic              sample_c;
    logic              poll_hit_c;
    logic              done_c;

    assign run_c      = (state == LATCH) || (state == LOW) || (state == HIGH);
    assign limit_c    = (state == LATCH) ? PH_W'(2 * HALF_CYCLES - 1) : PH_W'(HALF_CYCLES - 1);
    assign sample_c   = (state == LOW) && tick_c;
    assign poll_hit_c = auto_en && (poll_cnt == POLL_CYCLES - POLL_W'(1));
    assign done_c     = (state == HIGH) && tick_c && (bit_idx == BI_W'(NUM_BITS - 1));

    serial_pad_phase_timer #(
        .CNT_W (PH_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run_c),
        .limit  (limit_c),
        .last_c (tick_c)
    );

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        // Two-flop synchroniser for the asynchronous pad data line
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q1[p] <= 1'b1;
                sync_q2[p] <= 1'b1;
            end else begin
                sync_q1[p] <= pad_data[p];
                sync_q2[p] <= sync_q1[p];
            end
        end

        // Capture the inverted (active-high) bit on the last LOW cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shift_q[p] <= '0;
            end else if (sample_c) begin
                shift_q[p][bit_idx] <= ~sync_q2[p];
            end
        end

        assign shift_flat[p*NUM_BITS +: NUM_BITS] = shift_q[p];
    end

    // Scan sequencer with registered latch/clock/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            poll_cnt  <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            buttons   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (auto_en && !poll_hit_c) begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                    end else begin
                        poll_cnt <= '0;
                    end
                    if (start || poll_hit_c) begin
                        state     <= LATCH;
                        pad_latch <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LATCH: begin
                    if (tick_c) begin
                        state     <= LOW;
                        pad_latch <= 1'b0;
                        bit_idx   <= '0;
                    end
                end
                LOW: begin
                    if (tick_c) begin
                        state   <= HIGH;
                        pad_clk <= 1'b1;
                    end
                end
                HIGH: begin
                    if (tick_c) begin
                        pad_clk <= 1'b0;
                        if (done_c) begin
                            state   <= DONE;
                            buttons <= shift_flat;
                            valid   <= 1'b1;
                        end else begin
                            state   <= LOW;
                            bit_idx <= bit_idx + BI_W'(1);
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    poll_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_PAD_EDGE_EN
    // Newly pressed buttons, presented alongside valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed_edge <= '0;
        end else if (done_c) begin
            pressed_edge <= shift_flat & ~buttons;
        end else begin
            pressed_edge <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_serial_pad_reader.sv
// Bench for serial_pad_reader: NES (8-bit, auto-poll capable) and SNES (16-bit) instances.
module tb_serial_pad_reader;

    localparam int unsigned NP = 2;
    localparam int unsigned HC = 6;

    typedef struct packed {
        logic [31:0] btn;
        logic [31:0] edg;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic            start_a, auto_a, start_b;
    logic [NP-1:0]   pd_a, pd_b;
    logic            lat_a, pclk_a, val_a, busy_a;
    logic            lat_b, pclk_b, val_b, busy_b;
    logic [NP*8-1:0]  btn_a;
    logic [NP*16-1:0] btn_b;
`ifdef SERIAL_PAD_EDGE_EN
    logic [NP*8-1:0]  edge_a;
    logic [NP*16-1:0] edge_b;
`endif

    serial_pad_reader #(
        .NUM_PADS(NP), .NUM_BITS(8), .HALF_CYCLES(HC), .POLL_CYCLES(16'd100)
    ) u_nes (
        .clk(clk), .rst_n(rst_n), .start(start_a), .auto_en(auto_a), .pad_data(pd_a),
        .pad_latch(lat_a), .pad_clk(pclk_a), .buttons(btn_a), .valid(val_a), .busy(busy_a)
`ifdef SERIAL_PAD_EDGE_EN
        , .pressed_edge(edge_a)
`endif
    );

    serial_pad_reader #(
        .NUM_PADS(NP), .NUM_BITS(16), .HALF_CYCLES(HC), .POLL_CYCLES(16'd100)
    ) u_snes (
        .clk(clk), .rst_n(rst_n), .start(start_b), .auto_en(1'b0), .pad_data(pd_b),
        .pad_latch(lat_b), .pad_clk(pclk_b), .buttons(btn_b), .valid(val_b), .busy(busy_b)
`ifdef SERIAL_PAD_EDGE_EN
        , .pressed_edge(edge_b)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pad models: raw words are active-low, bit 0 is the first bit out
    logic [15:0] raw_a [NP];
    logic [15:0] raw_b [NP];
    int   idx_a = 0, idx_b = 0, len_a = 0, len_b = 0;
    logic lq_a = 1'b0, cq_a = 1'b0, lq_b = 1'b0, cq_b = 1'b0;
    logic pclk_seen = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            lq_a = 1'b0; cq_a = 1'b0; lq_b = 1'b0; cq_b = 1'b0;
        end
        if (lat_a && !lq_a) begin idx_a = 0; len_a = 0; end
        if (lat_a) len_a++;
        if (!lat_a && lq_a) check("nes_latch_width", 32'(len_a), 32'(2 * HC));
        if (pclk_a && !cq_a) begin idx_a++; pclk_seen = 1'b1; end
        if (lat_b && !lq_b) begin idx_b = 0; len_b = 0; end
        if (lat_b) len_b++;
        if (!lat_b && lq_b) check("snes_latch_width", 32'(len_b), 32'(2 * HC));
        if (pclk_b && !cq_b) begin idx_b++; pclk_seen = 1'b1; end
        for (int p = 0; p < NP; p++) begin
            pd_a[p] = (idx_a < 16) ? raw_a[p][idx_a[3:0]] : 1'b1;
            pd_b[p] = (idx_b < 16) ? raw_b[p][idx_b[3:0]] : 1'b1;
        end
        lq_a = lat_a; cq_a = pclk_a; lq_b = lat_b; cq_b = pclk_b;
    end

    exp_t q_a[$];
    exp_t q_b[$];

    // Scoreboard monitors: pop and compare whenever a DUT reports valid
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && val_a) begin
            if (q_a.size() == 0) begin
                check("nes_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q_a.pop_front();
                check("nes_buttons", 32'(btn_a), e.btn);
                check("nes_valid_cycle", 32'(cyc), e.cyc);
                check("nes_clk_pulses", 32'(idx_a), 32'd8);
                check("nes_busy_in_done", 32'(busy_a), 32'd1);
`ifdef SERIAL_PAD_EDGE_EN
                check("nes_pressed_edge", 32'(edge_a), e.edg);
`endif
            end
        end
        if (rst_n && val_b) begin
            if (q_b.size() == 0) begin
                check("snes_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q_b.pop_front();
                check("snes_buttons", 32'(btn_b), e.btn);
                check("snes_valid_cycle", 32'(cyc), e.cyc);
                check("snes_clk_pulses", 32'(idx_b), 32'd16);
`ifdef SERIAL_PAD_EDGE_EN
                check("snes_pressed_edge", 32'(edge_b), e.edg);
`endif
            end
        end
    end

    task automatic drain(input int budget);
        for (int n = 0; n < budget && (q_a.size() != 0 || q_b.size() != 0); n++) @(negedge clk);
        check("scoreboard_drain", 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    // Manual NES scan; optionally pokes start again while busy
    task automatic scan_a(input logic [15:0] r0, input logic [15:0] r1,
                          input logic [15:0] eb, input logic [15:0] ee, input bit extra);
        exp_t e;
        @(negedge clk);
        raw_a[0] = r0; raw_a[1] = r1;
        start_a = 1'b1;
        e.btn = 32'(eb); e.edg = 32'(ee); e.cyc = 32'(cyc + 109);
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        if (extra) begin
            repeat (48) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        drain(400);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   c;
        start_a = 1'b0; auto_a = 1'b0; start_b = 1'b0;
        pd_a = '1; pd_b = '1;
        for (int p = 0; p < NP; p++) begin raw_a[p] = 16'hFFFF; raw_b[p] = 16'hFFFF; end

        // Reset values and quiet idle
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_latch",   32'(lat_a),  32'd0);
        check("rst_pclk",    32'(pclk_a), 32'd0);
        check("rst_buttons", 32'(btn_a),  32'd0);
        check("rst_valid",   32'(val_a),  32'd0);
        check("rst_busy",    32'(busy_a), 32'd0);
        check("rst_buttons_snes", 32'(btn_b), 32'd0);
        check("rst_busy_snes",    32'(busy_b), 32'd0);
        pclk_seen = 1'b0;
        repeat (200) @(negedge clk);
        check("idle_no_pclk", 32'(pclk_seen), 32'd0);
        check("idle_busy", 32'(busy_a), 32'd0);

        // NES directed vectors: pad0 A+Right-ish pattern, single pads, all pressed
        scan_a(16'hFF7E, 16'hFFFF, 16'h0081, 16'h0081, 1'b0);
        scan_a(16'hFFFE, 16'hFF7F, 16'h8001, 16'h8000, 1'b1);
        scan_a(16'hFFFC, 16'hFF00, 16'hFF03, 16'h7F02, 1'b0);

        // SNES: pad0 all pressed, pad1 raw 5AFF
        @(negedge clk);
        raw_b[0] = 16'h0000; raw_b[1] = 16'h5AFF;
        start_b = 1'b1;
        e.btn = 32'hA500FFFF; e.edg = 32'hA500FFFF; e.cyc = 32'(cyc + 205);
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        drain(400);

        // Reset mid-scan while pad_clk is high: abort, no valid
        @(negedge clk);
        raw_a[0] = 16'hFF7E; raw_a[1] = 16'hFFFF;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_pclk_before", 32'(pclk_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pclk",    32'(pclk_a), 32'd0);
        check("mid_rst_latch",   32'(lat_a),  32'd0);
        check("mid_rst_buttons", 32'(btn_a),  32'd0);
        check("mid_rst_valid",   32'(val_a),  32'd0);
        check("mid_rst_busy",    32'(busy_a), 32'd0);
        check("mid_rst_snes_buttons", 32'(btn_b), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("mid_rst_no_valid", 32'(q_a.size() + q_b.size()), 32'd0);

        // Auto-poll: scans every 209 cycles; dropping auto_en mid-scan allows one more
        @(negedge clk);
        c = cyc;
        auto_a = 1'b1;
        e.btn = 32'h0081; e.edg = 32'h0081; e.cyc = 32'(c + 208); q_a.push_back(e);
        e.edg = 32'h0;                      e.cyc = 32'(c + 417); q_a.push_back(e);
        e.cyc = 32'(c + 626);               q_a.push_back(e);
        while (cyc < c + 560) @(negedge clk);
        auto_a = 1'b0;
        drain(400);
        repeat (300) @(negedge clk);
        check("auto_stop_no_extra", 32'(q_a.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
